// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Request/grant/split signal bundle between the two system-bus
//                masters, the split-capable slaves and the bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if;
   logic [1:0] m_req;            // per-master request, level, held for the transaction
   logic       split;            // slave split indication
   logic       split_ready;      // split slave data-ready pulse
   logic [1:0] m_grant;          // one-hot or zero grant
   logic       owner;            // current/last owner, bus mux select
   logic       bus_busy;         // any grant asserted
   logic [1:0] m_split_pending;  // per-master split-parked flag
   logic       split_timeout;    // pending split abandoned

   // Arbiter side: consumes requests and split status, drives grants.
   modport master (
      input  m_req,
      input  split,
      input  split_ready,
      output m_grant,
      output owner,
      output bus_busy,
      output m_split_pending,
      output split_timeout
   );

   // Requester/slave side: drives requests and split status, observes grants.
   modport slave (
      output m_req,
      output split,
      output split_ready,
      input  m_grant,
      input  owner,
      input  bus_busy,
      input  m_split_pending,
      input  split_timeout
   );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master, split-aware system-bus arbiter. Fixed priority
//                (master index 0 first) with a tenure limit, parking of a
//                master whose slave splits, and prioritised resume of that
//                master once the slave reports data ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
   parameter int MAX_HOLD      = 16,   // max tenure while the other master waits (>=2)
   parameter int SPLIT_TIMEOUT = 256,  // cycles a split may stay pending (>=2)
   parameter int CNT_W         = 9     // counter width, holds max(MAX_HOLD, SPLIT_TIMEOUT)
) (
   input wire            clk,
   input wire            rst,
   bus_arbiter_if.master bus
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(SPLIT_TIMEOUT - 1);

   state_t           r_state;
   logic [1:0]       r_grant;
   logic             r_owner;
   logic             r_busy;
   logic [1:0]       r_pending;
   logic             r_timeout;
   logic             r_ready;       // split slave has data for the parked master
   logic             r_resumed;     // current tenure is a resumed split transaction
   logic             r_excl_valid;  // one-cycle exclusion after a forced release
   logic             r_excl_idx;    // master excluded by the forced release
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] r_to_cnt;

   logic             w_any_pending;
   logic             w_pend_idx;
   logic [1:0]       w_eligible;
   logic [1:0]       w_excl_mask;
   logic [1:0]       w_candidates;
   logic             w_pick;
   logic             w_other;
   logic             w_other_eligible;
   logic             w_owner_req;

   // Arbitration inputs: who is eligible, who may win this IDLE cycle.
   always_comb begin
      w_any_pending    = |r_pending;
      // At most one split is ever pending, so a single bit names the parked master.
      w_pend_idx       = r_pending[1];
      w_eligible       = bus.m_req & ~r_pending;
      w_excl_mask      = 2'b00;
      if (r_excl_valid) begin
         w_excl_mask = r_excl_idx ? 2'b10 : 2'b01;
      end
      w_candidates     = w_eligible & ~w_excl_mask;
      // Lowest index wins; only meaningful when w_candidates is non-zero.
      w_pick           = ~w_candidates[0];
      w_other          = ~r_owner;
      w_other_eligible = w_eligible[w_other];
      w_owner_req      = bus.m_req[r_owner];
   end

   // Arbiter FSM with registered grant, split bookkeeping and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= 2'b00;
         r_owner      <= 1'b0;
         r_busy       <= 1'b0;
         r_pending    <= 2'b00;
         r_timeout    <= 1'b0;
         r_ready      <= 1'b0;
         r_resumed    <= 1'b0;
         r_excl_valid <= 1'b0;
         r_excl_idx   <= 1'b0;
         r_hold_cnt   <= '0;
         r_to_cnt     <= '0;
      end else begin
         r_timeout    <= 1'b0;
         r_excl_valid <= 1'b0;

         // Pending split: latch data-ready, otherwise age it towards abandonment.
         // A ready pulse coinciding with the last timeout cycle wins.
         if (w_any_pending) begin
            if (bus.split_ready) begin
               r_ready <= 1'b1;
            end else if (!r_ready) begin
               if (r_to_cnt == c_to_last) begin
                  r_pending <= 2'b00;
                  r_timeout <= 1'b1;
                  r_to_cnt  <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
         end

         case (r_state)
            S_IDLE: begin
               if (r_ready && bus.m_req[w_pend_idx]) begin
                  // Resume the parked master ahead of any fresh request.
                  r_grant    <= {w_pend_idx, ~w_pend_idx};
                  r_owner    <= w_pend_idx;
                  r_busy     <= 1'b1;
                  r_pending  <= 2'b00;
                  r_ready    <= 1'b0;
                  r_resumed  <= 1'b1;
                  r_hold_cnt <= '0;
                  r_state    <= S_BUSY;
               end else if (r_ready) begin
                  // Parked master gave up its request: forget the split.
                  r_pending <= 2'b00;
                  r_ready   <= 1'b0;
               end else if (w_candidates != 2'b00) begin
                  r_grant    <= {w_pick, ~w_pick};
                  r_owner    <= w_pick;
                  r_busy     <= 1'b1;
                  r_resumed  <= 1'b0;
                  r_hold_cnt <= '0;
                  r_state    <= S_BUSY;
               end
            end

            S_BUSY: begin
               if (!w_owner_req) begin
                  r_grant <= 2'b00;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (bus.split && !r_resumed && !w_any_pending) begin
                  // Park the owner; a ready pulse in this same cycle is kept.
                  r_pending <= {r_owner, ~r_owner};
                  r_ready   <= bus.split_ready;
                  r_to_cnt  <= '0;
                  r_grant   <= 2'b00;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else if ((r_hold_cnt == c_hold_last) && w_other_eligible) begin
                  // Tenure exhausted: hand the bus over via one idle cycle.
                  r_grant      <= 2'b00;
                  r_busy       <= 1'b0;
                  r_excl_valid <= 1'b1;
                  r_excl_idx   <= r_owner;
                  r_state      <= S_IDLE;
               end else if (r_hold_cnt != c_hold_last) begin
                  // Saturate so a late request from the other master releases promptly.
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end

            default: begin
               r_grant <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.m_grant         = r_grant;
   assign bus.owner           = r_owner;
   assign bus.bus_busy        = r_busy;
   assign bus.m_split_pending = r_pending;
   assign bus.split_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter: directed scenarios with
//                literal expectations plus a per-cycle behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
   localparam int MAX_HOLD      = 16;
   localparam int SPLIT_TIMEOUT = 256;
   localparam int CNT_W         = 9;

   logic clk;
   logic rst;

   bus_arbiter_if bus_if ();

   bus_arbiter #(
      .MAX_HOLD      (MAX_HOLD),
      .SPLIT_TIMEOUT (SPLIT_TIMEOUT),
      .CNT_W         (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int md_who     = -1;  // master holding the bus, -1 when free
   int md_last    = 0;   // most recent owner
   int md_tenure  = 0;   // cycles the current owner has held the bus
   int md_pend    = -1;  // parked master, -1 when none
   int md_age     = 0;   // cycles the split has been pending without ready
   bit md_rdy     = 1'b0;
   bit md_resumed = 1'b0;
   bit md_pulse   = 1'b0;
   int md_excl    = -1;  // master barred from the next arbitration

   function automatic logic [1:0] onehot(input int who);
      if (who < 0) return 2'b00;
      return (who == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic model_step();
      int n_who, n_last, n_tenure, n_pend, n_age, n_excl, other;
      bit n_rdy, n_resumed, n_pulse;
      logic [1:0] req;
      req = bus_if.m_req;
      if (rst) begin
         md_who = -1; md_last = 0; md_tenure = 0; md_pend = -1; md_age = 0;
         md_rdy = 1'b0; md_resumed = 1'b0; md_pulse = 1'b0; md_excl = -1;
         return;
      end
      n_who = md_who; n_last = md_last; n_tenure = md_tenure; n_pend = md_pend;
      n_age = md_age; n_rdy = md_rdy; n_resumed = md_resumed; n_pulse = 1'b0; n_excl = -1;

      if (md_pend >= 0) begin
         if (bus_if.split_ready) n_rdy = 1'b1;
         else if (!md_rdy) begin
            if (md_age >= SPLIT_TIMEOUT - 1) begin
               n_pend = -1; n_pulse = 1'b1;
            end else n_age = md_age + 1;
         end
      end

      if (md_who < 0) begin
         if (md_rdy) begin
            if (req[md_pend]) begin
               n_who = md_pend; n_last = md_pend; n_tenure = 0; n_resumed = 1'b1;
            end
            n_pend = -1; n_rdy = 1'b0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (n_who < 0 && req[i] && md_pend != i && md_excl != i) begin
                  n_who = i; n_last = i; n_tenure = 0; n_resumed = 1'b0;
               end
            end
         end
      end else begin
         other = 1 - md_who;
         if (!req[md_who]) n_who = -1;
         else if (bus_if.split && !md_resumed && md_pend < 0) begin
            n_pend = md_who; n_age = 0; n_rdy = bus_if.split_ready; n_who = -1;
         end else if (md_tenure >= MAX_HOLD - 1 && req[other] && md_pend != other) begin
            n_excl = md_who; n_who = -1;
         end else n_tenure = md_tenure + 1;
      end

      md_who = n_who; md_last = n_last; md_tenure = n_tenure; md_pend = n_pend;
      md_age = n_age; md_rdy = n_rdy; md_resumed = n_resumed; md_pulse = n_pulse;
      md_excl = n_excl;
   endtask

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         check("model grant",   32'(bus_if.m_grant),         32'(onehot(md_who)));
         check("model owner",   32'(bus_if.owner),           32'(md_last[0]));
         check("model busy",    32'(bus_if.bus_busy),        32'(md_who >= 0));
         check("model pending", 32'(bus_if.m_split_pending), 32'(onehot(md_pend)));
         check("model timeout", 32'(bus_if.split_timeout),   32'(md_pulse));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // Directed scenarios with hand-computed expectations.
   initial begin
      int n;
      rst = 1'b1;
      bus_if.m_req = 2'b00; bus_if.split = 1'b0; bus_if.split_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset grant",   32'(bus_if.m_grant),         32'd0);
      check("reset owner",   32'(bus_if.owner),           32'd0);
      check("reset busy",    32'(bus_if.bus_busy),        32'd0);
      check("reset pending", 32'(bus_if.m_split_pending), 32'd0);
      check("reset timeout", 32'(bus_if.split_timeout),   32'd0);

      // Single request, one-cycle latency, release.
      rst = 1'b0; bus_if.m_req = 2'b01;
      @(negedge clk);
      check("single grant", 32'(bus_if.m_grant),  32'h1);
      check("single owner", 32'(bus_if.owner),    32'd0);
      check("single busy",  32'(bus_if.bus_busy), 32'd1);
      bus_if.m_req = 2'b00;
      @(negedge clk);
      check("single release", 32'(bus_if.m_grant), 32'h0);

      // Both request: master index 0 wins, tenure limit hands over after 16 cycles.
      bus_if.m_req = 2'b11;
      @(negedge clk);
      check("prio grant", 32'(bus_if.m_grant), 32'h1);
      n = 0;
      while (bus_if.m_grant == 2'b01 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("hold tenure", 32'(n), 32'd16);
      check("handover gap", 32'(bus_if.m_grant), 32'h0);
      @(negedge clk);
      check("handover grant", 32'(bus_if.m_grant), 32'h2);
      check("handover owner", 32'(bus_if.owner),   32'd1);

      // Master 2 split, master 1 served, ready latched, master 2 resumed.
      bus_if.m_req = 2'b10; bus_if.split = 1'b1;
      @(negedge clk);
      bus_if.split = 1'b0;
      check("split pending", 32'(bus_if.m_split_pending), 32'h2);
      check("split drop",    32'(bus_if.m_grant),         32'h0);
      bus_if.m_req = 2'b11;
      @(negedge clk);
      check("split other grant", 32'(bus_if.m_grant), 32'h1);
      bus_if.split_ready = 1'b1;
      @(negedge clk);
      bus_if.split_ready = 1'b0;
      bus_if.m_req = 2'b10;
      @(negedge clk);
      check("resume gap", 32'(bus_if.m_grant), 32'h0);
      @(negedge clk);
      check("resume grant",   32'(bus_if.m_grant),         32'h2);
      check("resume pending", 32'(bus_if.m_split_pending), 32'h0);

      // Split from a resumed owner is ignored; stray ready changes nothing.
      bus_if.split = 1'b1;
      @(negedge clk);
      bus_if.split = 1'b0;
      check("resumed split grant",   32'(bus_if.m_grant),         32'h2);
      check("resumed split pending", 32'(bus_if.m_split_pending), 32'h0);
      bus_if.split_ready = 1'b1;
      @(negedge clk);
      bus_if.split_ready = 1'b0;
      check("stray ready pending", 32'(bus_if.m_split_pending), 32'h0);
      check("stray ready grant",   32'(bus_if.m_grant),         32'h2);
      bus_if.m_req = 2'b00;
      @(negedge clk);

      // Split and ready in the same cycle: resumed immediately.
      bus_if.m_req = 2'b10;
      @(negedge clk);
      bus_if.split = 1'b1; bus_if.split_ready = 1'b1;
      @(negedge clk);
      bus_if.split = 1'b0; bus_if.split_ready = 1'b0;
      check("same-cycle pending", 32'(bus_if.m_split_pending), 32'h2);
      @(negedge clk);
      check("same-cycle resume", 32'(bus_if.m_grant), 32'h2);
      bus_if.m_req = 2'b00;
      @(negedge clk);

      // Split abandoned after SPLIT_TIMEOUT cycles.
      bus_if.m_req = 2'b10;
      @(negedge clk);
      bus_if.split = 1'b1;
      @(negedge clk);
      bus_if.split = 1'b0;
      check("timeout pending", 32'(bus_if.m_split_pending), 32'h2);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_if.split_timeout && n < 300);
      check("timeout cycles",  32'(n),                       32'd256);
      check("timeout cleared", 32'(bus_if.m_split_pending), 32'h0);
      @(negedge clk);
      check("timeout regrant", 32'(bus_if.m_grant),       32'h2);
      check("timeout single",  32'(bus_if.split_timeout), 32'd0);

      // Ready in the timeout cycle wins.
      bus_if.split = 1'b1;
      @(negedge clk);
      bus_if.split = 1'b0;
      repeat (255) @(negedge clk);
      bus_if.split_ready = 1'b1;
      @(negedge clk);
      bus_if.split_ready = 1'b0;
      check("race no timeout", 32'(bus_if.split_timeout),   32'd0);
      check("race pending",    32'(bus_if.m_split_pending), 32'h2);
      @(negedge clk);
      check("race resume", 32'(bus_if.m_grant), 32'h2);
      bus_if.m_req = 2'b00;
      @(negedge clk);

      // Reset while busy with a split pending.
      bus_if.m_req = 2'b10;
      @(negedge clk);
      bus_if.split = 1'b1; bus_if.m_req = 2'b11;
      @(negedge clk);
      bus_if.split = 1'b0;
      @(negedge clk);
      check("pre-reset grant", 32'(bus_if.m_grant), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("mid reset grant",   32'(bus_if.m_grant),         32'h0);
      check("mid reset pending", 32'(bus_if.m_split_pending), 32'h0);
      check("mid reset busy",    32'(bus_if.bus_busy),        32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post reset grant", 32'(bus_if.m_grant), 32'h1);
      bus_if.m_req = 2'b00;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, split-aware arbiter for the shared system bus.
- Grants bus ownership to master 1 (index 0) or master 2 (index 1) by fixed priority with a tenure limit.
- Parks a master whose slave signals split, and re-grants it ahead of fresh requests when that slave reports data ready.
- Sits between the master ports and the bus address/data mux; drives the mux select and the per-master grant lines.

Parameters:
- MAX_HOLD, 16, max consecutive cycles an owner keeps the bus while the other master is eligible and requesting (≥2).
- SPLIT_TIMEOUT, 256, cycles a split may stay pending before it is abandoned (≥2).
- CNT_W, 9, width of the hold and timeout counters; must hold max(MAX_HOLD, SPLIT_TIMEOUT).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- m_req  in  2  per-master bus request, level; held high for the whole transaction.
- split  in  1  slave split indication, sampled only while BUSY.
- split_ready  in  1  split slave data-ready, 1-cycle pulse.
- m_grant  out  2  one-hot or zero grant, registered.
- owner  out  1  index of the current/last owner, drives the bus mux select.
- bus_busy  out  1  high while any grant is asserted.
- m_split_pending  out  2  per-master split-parked flag.
- split_timeout  out  1  1-cycle pulse when a pending split is abandoned.

Behaviour:
- Reset (sampled at clk edge, wins over everything): state IDLE; m_grant=0, owner=0, bus_busy=0, m_split_pending=0, split_timeout=0; ready latch, resumed flag, hold and timeout counters cleared. A reset asserted mid-transaction drops the grant at that edge.
- Eligible master: m_req[i]=1 and m_split_pending[i]=0.
- IDLE, evaluated in priority order each cycle:
  - Resume: ready latch set and the pending master's m_req is high. Grant it next edge, clear its pending flag and the ready latch, set resumed=1, go to BUSY.
  - Pending master's m_req low when the ready latch is set: clear pending and latch, grant nothing.
  - Otherwise grant the lowest-index eligible master next edge, resumed=0, go to BUSY.
  - Grant latency is 1 cycle from the sampled request. owner updates with the grant.
- BUSY, evaluated in priority order:
  - m_req[owner]=0: drop grant next edge, go to IDLE.
  - split=1 while resumed=0 and no split pending: set m_split_pending[owner], drop grant, go to IDLE, start the timeout counter at 0.
  - split while resumed=1 or while a split is already pending is ignored; the transaction continues.
  - Hold counter: increments each BUSY cycle and resets on every new grant. When it equals MAX_HOLD-1 and the other master is eligible, drop the grant and go to IDLE.
  - After a forced release, the next IDLE arbitration excludes the previous owner for that cycle. The other master then wins even if it has higher index.
- Handover: at least one all-zero grant cycle between owners. m_grant is never two-hot.
- split_ready:
  - Any state with a split pending: set the ready latch.
  - No split pending: ignored.
  - split_ready in the same cycle as the split that creates the pending flag: latched.
- Timeout counter:
  - Runs while a split is pending and the ready latch is clear.
  - At SPLIT_TIMEOUT-1: clear pending, pulse split_timeout for 1 cycle; that master becomes eligible again.
  - split_ready arriving in the same cycle as the timeout: ready wins, no timeout pulse.
- bus_busy equals the OR of m_grant (registered).

Test Plan:
- Reset then m_req=2'b01 → m_grant=2'b01 one cycle later, owner=0, bus_busy=1. Drop req → m_grant=0 next cycle.
- m_req=2'b11 from IDLE → master 1 granted. Master 1 holds 16 cycles → grant drops after cycle 16, one idle cycle, then m_grant=2'b10, owner=1.
- Master 2 owns the bus, split=1 → m_split_pending=2'b10, grant drops. Master 1 req → granted. split_ready pulse during master 1 tenure → latched. Master 1 releases → m_grant=2'b10 (resume), pending=0.
- Master 2 split pending, no split_ready for 256 cycles → split_timeout pulses once, pending=0. Master 2 req still high → granted next IDLE.
- Resumed owner asserts split → ignored, grant stays. split_ready with nothing pending → no state change.
- rst asserted while BUSY with a split pending → all outputs 0 at the next edge. With req held, grant reappears 1 cycle after rst deasserts.
